sumador_serial: RTL and testbench

SUMADOR_SERIAL -- requirements
Module: sumador_serial

---
 rtl/sumador_serial.sv | 140 ++++++++++++++
 tb/tb_sumador_serial.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sumador_serial.sv
// Serial adder/subtractor: WIDTH-bit operands are processed CHUNK bits per clock, LSB chunk first.
// Define SUMADOR_OVERFLOW_EN to build the two's-complement overflow flag; otherwise it is tied to 0.
module sumador_serial #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("sumador_serial: CHUNK must be in 1..WIDTH and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_out_reg;
    logic [CHUNK:0]   chunk_sum;
    logic [N-1:0]     chunk_sel;
    logic             accept;
    logic             last;

    assign accept = start && (state_reg != RUN);
    assign last   = (cnt_reg == CW'(N - 1));

    // Operands shift right as they are consumed, so the active chunk always sits in the low bits.
    assign chunk_sum = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_reg};

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_sel
            assign chunk_sel[gi] = (state_reg == RUN) && (cnt_reg == CW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            carry_out_reg <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1, so the inversion and the +1 are folded in at load time.
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub | carry_in;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_reg     <= a_reg >> CHUNK;
            b_reg     <= b_reg >> CHUNK;
            carry_reg <= chunk_sum[CHUNK];
            if (last) begin
                carry_out_reg <= chunk_sum[CHUNK];
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (chunk_sel[i]) begin
                    sum_reg[i*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                end
            end
        end
    end

`ifdef SUMADOR_OVERFLOW_EN
    logic overflow_reg;

    // Carry into the MSB is recovered as a^b^s of that bit, then compared with the carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (state_reg == RUN && last) begin
            overflow_reg <= a_reg[CHUNK-1] ^ b_reg[CHUNK-1]
                          ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];
        end
    end

    assign overflow = overflow_reg;
`else
    assign overflow = 1'b0;
`endif

    assign busy      = (state_reg == RUN);
    assign done      = (state_reg == DONE);
    assign sum       = sum_reg;
    assign carry_out = carry_out_reg;

endmodule

// File: tb/tb_sumador_serial.sv
// Scoreboard bench for sumador_serial: an 8-bit/2-bit-chunk instance plus a 1-bit full-adder instance.
module tb_sumador_serial;

    localparam int W = 8;
    localparam int C = 2;
    localparam int N = W / C;

`ifdef SUMADOR_OVERFLOW_EN
    localparam bit OV_EN = 1'b1;
`else
    localparam bit OV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
    logic busy1, done1, sum1, cout1, ovf1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int op_id = 0;

    typedef struct {
        int id;
        int s;
        bit co;
        bit ov;
        int due;
    } exp_t;

    exp_t q[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sumador_serial #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .carry_in(cin), .sub(sub), .busy(busy), .done(done),
        .sum(sum), .carry_out(cout), .overflow(ovf)
    );

    sumador_serial #(.WIDTH(1), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .carry_in(cin1), .sub(sub1), .busy(busy1), .done(done1),
        .sum(sum1), .carry_out(cout1), .overflow(ovf1)
    );

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input int w, input int ua, input int ub, input bit ci,
                                  input bit subm, output int s, output bit co, output bit ov);
        int m, sa, sb, r, sr;
        m  = 1 << w;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (!subm) begin
            r  = ua + ub + int'(ci);
            sr = sa + sb + int'(ci);
            co = (r >= m);
        end else begin
            r  = ua - ub;
            sr = sa - sb;
            co = (ua >= ub);
        end
        s  = ((r % m) + m) % m;
        ov = OV_EN && (sr >= m / 2 || sr < -(m / 2));
    endfunction

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", int'(sum), e.s);
                check("carry_out", int'(cout), int'(e.co));
                check("overflow", int'(ovf), int'(e.ov));
                check("done_cycle", cyc, e.due);
                check("busy_at_done", int'(busy), 0);
                $display("op %0d: sum=%02h carry_out=%0d overflow=%0d cycle=%0d",
                         e.id, sum, cout, ovf, cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                check("spurious_done1", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("sum1", int'(sum1), e.s);
                check("carry_out1", int'(cout1), int'(e.co));
                check("overflow1", int'(ovf1), int'(e.ov));
                check("done_cycle1", cyc, e.due);
                $display("fa %0d: sum=%0d carry_out=%0d cycle=%0d", e.id, sum1, cout1, cyc);
            end
        end
    end

    // Issued at a negedge; the next posedge accepts, done is visible N cycles later.
    task automatic push_expected(input int x, input int y, input bit ci, input bit sb);
        exp_t e;
        model(W, x, y, ci, sb, e.s, e.co, e.ov);
        e.id  = op_id++;
        e.due = cyc + 1 + N;
        q.push_back(e);
    endtask

    task automatic op(input int x, input int y, input bit ci, input bit sb, input bit disturb);
        push_expected(x, y, ci, sb);
        a = W'(x); b = W'(y); cin = ci; sub = sb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= N; k++) begin
            check("busy_run", int'(busy), 1);
            if (disturb) begin
                a = W'($urandom); b = W'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
                start = (k == 1);
            end
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_carry_out", int'(cout), 0);
        check("rst_overflow", int'(ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1-bit full-adder truth table
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            a1 = 1'((i >> 2) & 1); b1 = 1'((i >> 1) & 1); cin1 = 1'(i & 1); sub1 = 1'b0;
            model(1, int'(a1), int'(b1), cin1, 1'b0, e.s, e.co, e.ov);
            e.id = i; e.due = cyc + 2;
            q1.push_back(e);
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            repeat (2) @(negedge clk);
        end

        op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
        op(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
        op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
        op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        op(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Back-to-back with start held high; operands scrambled during RUN
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int x, y;
            bit ci, sb;
            x = int'($urandom_range(0, 255)); y = int'($urandom_range(0, 255));
            ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
            push_expected(x, y, ci, sb);
            a = W'(x); b = W'(y); cin = ci; sub = sb;
            for (int j = 0; j < N + 1; j++) begin
                @(negedge clk);
                if (j < N) begin
                    check("busy_b2b", int'(busy), 1);
                    a = W'($urandom); b = W'($urandom);
                end
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the third RUN cycle aborts the operation
        op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
        a = 8'h33; b = 8'h11; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_before_abort", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_sum", int'(sum), 0);
        check("abort_carry_out", int'(cout), 0);
        check("abort_overflow", int'(ovf), 0);
        q.delete();
        repeat (2) @(negedge clk);
        check("abort_done_held", int'(done), 0);
        rst_n = 1'b1;
        repeat (N + 2) @(negedge clk);
        check("abort_idle_busy", int'(busy), 0);
        op(8'h20, 8'h22, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("pending_ops", q.size(), 0);
        check("pending_ops1", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
